// File: rtl/q2_pkg.sv
// rtl/q2_pkg.sv - shared state encodings and ALU step count for the q2 sequencer
package q2_pkg;

    // Low two bits are {s1,s0}; ALU keeps them at 00 and is flagged by bit 2.
    typedef enum logic [2:0] {
        FETCH = 3'b000,
        DEREF = 3'b001,
        LOAD  = 3'b010,
        EXEC  = 3'b011,
        ALU   = 3'b100
    } q2_state_e;

    localparam int         ALU_STEPS = 8;
    localparam logic [2:0] ALU_LAST  = 3'(ALU_STEPS - 1);

endpackage

// File: rtl/q2_step_sync.sv
// rtl/q2_step_sync.sv - two-flop synchroniser and rising-edge detector for the step key
module q2_step_sync (
    input  logic clk,
    input  logic nrst,
    input  logic step,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], step};
            prev <= sync[1];
        end
    end

    assign rise = sync[1] & ~prev;

endmodule

// File: rtl/q2_sequencer.sv
// rtl/q2_sequencer.sv - two-phase major-state sequencer with ALU shift loop and run/step control
module q2_sequencer
    import q2_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       deref,
    input  logic       o2,
    input  logic       s2in,
    input  logic       run,
    input  logic       step,
    output logic       s0,
    output logic       ns0,
    output logic       s1,
    output logic       ns1,
    output logic       s2,
    output logic       s3,
    output logic       ws,
    output logic       halted,
    output logic [2:0] bitcnt
);

    q2_state_e state;
    logic      pending;
    logic      step_rise;
    logic      park;

    q2_step_sync u_step_sync (
        .clk  (clk),
        .nrst (nrst),
        .step (step),
        .rise (step_rise)
    );

    assign park = !run && !pending;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= FETCH;
            ws      <= 1'b0;
            bitcnt  <= 3'd0;
            halted  <= 1'b1;
            pending <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
        end else if (halted) begin
            // Step edges only count while parked, so an edge during the released
            // instruction cannot queue a second one.
            if (run || pending) begin
                halted  <= 1'b0;
                pending <= 1'b0;
            end else if (step_rise) begin
                pending <= 1'b1;
            end
        end else if (!ws) begin
            ws <= 1'b1;
        end else begin
            ws <= 1'b0;
            case (state)
                FETCH: state <= deref ? DEREF : (!o2 ? LOAD : EXEC);
                DEREF: state <= !o2 ? LOAD : EXEC;
                LOAD:  state <= EXEC;
                EXEC: begin
                    if (s2in) begin
                        state  <= ALU;
                        bitcnt <= 3'd0;
                        s2     <= 1'b1;
                        s3     <= 1'b0;
                    end else begin
                        state  <= FETCH;
                        halted <= park;
                    end
                end
                ALU: begin
                    if (bitcnt == ALU_LAST) begin
                        state  <= FETCH;
                        bitcnt <= 3'd0;
                        s2     <= 1'b0;
                        s3     <= 1'b0;
                        halted <= park;
                    end else begin
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == ALU_LAST - 3'd1) begin
                            s2 <= 1'b0;
                            s3 <= 1'b1;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign s0  = state[0];
    assign s1  = state[1];
    assign ns0 = ~state[0];
    assign ns1 = ~state[1];

endmodule

// File: tb/tb_q2_sequencer.sv
// tb/tb_q2_sequencer.sv - directed and randomized checks of q2_sequencer against a step-list model
module tb_q2_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       deref = 1'b0;
    logic       o2 = 1'b1;
    logic       s2in = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       s0, ns0, s1, ns1, s2, s3, ws, halted;
    logic [2:0] bitcnt;

    always #5 clk = ~clk;

    q2_sequencer dut (
        .clk    (clk),
        .nrst   (nrst),
        .deref  (deref),
        .o2     (o2),
        .s2in   (s2in),
        .run    (run),
        .step   (step),
        .s0     (s0),
        .ns0    (ns0),
        .s1     (s1),
        .ns1    (ns1),
        .s2     (s2),
        .s3     (s3),
        .ws     (ws),
        .halted (halted),
        .bitcnt (bitcnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction position: 0 fetch, 1 deref, 2 load, 3 exec, 4+k = ALU step k.
    int m_step = 0, m_phase = 0, m_parked = 1, m_pending = 0, m_valid = 0;
    int h_a = 0, h_b = 0, h_c = 0;

    function automatic int next_step(input int cur);
        if (cur == 0)       return deref ? 1 : (o2 ? 3 : 2);
        else if (cur == 1)  return o2 ? 3 : 2;
        else if (cur == 2)  return 3;
        else if (cur == 3)  return s2in ? 4 : -1;
        else if (cur < 11)  return cur + 1;
        else                return -1;
    endfunction

    task automatic model_edge();
        int rise;
        int nxt;
        if (!nrst) begin
            m_step = 0; m_phase = 0; m_parked = 1; m_pending = 0;
            h_a = 0; h_b = 0; h_c = 0;
            m_valid = 1;
        end else begin
            rise = (h_b == 1 && h_c == 0) ? 1 : 0;
            h_c = h_b; h_b = h_a; h_a = step ? 1 : 0;
            if (m_parked == 1) begin
                if (run || m_pending == 1) begin
                    m_parked = 0; m_pending = 0;
                end else if (rise == 1) begin
                    m_pending = 1;
                end
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else begin
                m_phase = 0;
                nxt = next_step(m_step);
                if (nxt < 0) begin
                    m_step = 0;
                    m_parked = (!run && m_pending == 0) ? 1 : 0;
                end else begin
                    m_step = nxt;
                end
            end
        end
    endtask

    function automatic int model_vec();
        int bc, v0, v1, v2, v3;
        v0 = (m_step < 4) ? m_step % 2 : 0;
        v1 = (m_step < 4) ? m_step / 2 : 0;
        v2 = (m_step >= 4 && m_step <= 10) ? 1 : 0;
        v3 = (m_step == 11) ? 1 : 0;
        bc = (m_step >= 4) ? m_step - 4 : 0;
        return m_parked * 1024 + m_phase * 512 + bc * 64 + v3 * 32 + v2 * 16
             + v1 * 8 + v0 * 4 + (1 - v1) * 2 + (1 - v0);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_valid == 1)
            expect_eq("model", 32'({halted, ws, bitcnt, s3, s2, s1, s0, ns1, ns0}), 32'(model_vec()));
    endtask

    task automatic expect_cyc(input string tag, input int major, input int w, input int h);
        expect_eq(tag, 32'({s1, s0, ws, halted}), 32'(major * 4 + w * 2 + h));
    endtask

    int ind_seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        nrst = 1'b0; run = 1'b0;
        repeat (2) cycle();
        expect_eq("rst_halted", 32'(halted), 1);
        expect_eq("rst_ns", 32'({ns1, ns0}), 3);
        expect_eq("rst_state", 32'({s3, s2, s1, s0}), 0);
        expect_eq("rst_ws_bitcnt", 32'({ws, bitcnt}), 0);

        nrst = 1'b1; run = 1'b1; deref = 1'b0; o2 = 1'b1; s2in = 1'b0;
        cycle(); expect_cyc("boot0", 0, 0, 0);
        cycle(); expect_cyc("boot1", 0, 1, 0);
        cycle(); expect_cyc("boot2", 3, 0, 0);
        cycle(); expect_cyc("boot3", 3, 1, 0);
        cycle(); expect_cyc("boot4", 0, 0, 0);

        deref = 1'b1; o2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            expect_cyc("indirect", ind_seq[i], (i % 2 == 0) ? 1 : 0, 0);
        end

        deref = 1'b0; o2 = 1'b1; s2in = 1'b1;
        cycle(); expect_cyc("alu_f1", 0, 1, 0);
        cycle(); expect_cyc("alu_e0", 3, 0, 0);
        cycle(); expect_cyc("alu_e1", 3, 1, 0);
        for (int i = 0; i < 16; i++) begin
            int k;
            cycle();
            if (i == 0) s2in = 1'b0;
            k = i / 2;
            expect_eq("alu_step", 32'({s3, s2, bitcnt, ws, s1, s0}),
                      32'({k == 7, k < 7, 3'(k), 1'(i % 2), 2'b00}));
        end
        cycle(); expect_cyc("alu_exit", 0, 0, 0);
        expect_eq("alu_exit_cnt", 32'({s3, s2, bitcnt}), 0);

        o2 = 1'b0;
        cycle(); expect_cyc("drop_f1", 0, 1, 0);
        cycle(); expect_cyc("drop_l0", 2, 0, 0);
        run = 1'b0;
        cycle(); expect_cyc("drop_l1", 2, 1, 0);
        cycle(); expect_cyc("drop_e0", 3, 0, 0);
        cycle(); expect_cyc("drop_e1", 3, 1, 0);
        cycle(); expect_cyc("drop_park", 0, 0, 1);
        repeat (20) begin
            cycle(); expect_cyc("park_hold", 0, 0, 1);
        end

        o2 = 1'b1; step = 1'b1;
        repeat (3) cycle();
        expect_cyc("step_pend", 0, 0, 1);
        step = 1'b0;
        cycle(); expect_cyc("step_go", 0, 0, 0);
        step = 1'b1;
        cycle(); expect_cyc("step_f1", 0, 1, 0);
        cycle(); expect_cyc("step_e0", 3, 0, 0);
        cycle(); expect_cyc("step_e1", 3, 1, 0);
        cycle(); expect_cyc("step_park", 0, 0, 1);
        repeat (15) begin
            cycle(); expect_cyc("step_hold", 0, 0, 1);
        end
        step = 1'b0;

        run = 1'b1; s2in = 1'b1;
        for (int i = 0; i < 60 && !(s2 === 1'b1 && bitcnt === 3'd4); i++) cycle();
        expect_eq("reach_alu4", 32'({s2, bitcnt}), 32'({1'b1, 3'd4}));
        nrst = 1'b0;
        cycle();
        expect_eq("mid_reset", 32'({s3, s2, s1, s0, ws, halted, bitcnt}), 32'({4'b0000, 1'b0, 1'b1, 3'd0}));
        nrst = 1'b1; s2in = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            nrst  = ($urandom_range(0, 255) != 0);
            run   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) step = ~step;
            deref = 1'($urandom);
            o2    = 1'($urandom);
            s2in  = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q2_sequencer.md
Q2_SEQUENCER -- requirements
Module: q2_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all state changes on its rising edge.
REQ-002 SHALL have ports: nrst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have ports: deref  input  1  indirect bit of the current instruction, valid from the FETCH write phase.
REQ-004 SHALL have ports: o2  input  1  opcode bit 2; 0 means the instruction needs a memory operand (LOAD).
REQ-005 SHALL have ports: s2in  input  1  request from the control decode to enter the ALU shift sequence, sampled at the end of EXEC.
REQ-006 SHALL have ports: run  input  1  front-panel run level; 1 runs free, 0 halts at the instruction boundary.
REQ-007 SHALL have ports: step  input  1  front-panel step level; each 0->1 edge releases one full instruction while halted.
REQ-008 SHALL have ports: s0, ns0, s1, ns1  output  1 each  major-state bits and their complements.
REQ-009 SHALL have ports: s2, s3  output  1 each  ALU shift-state bits.
REQ-010 SHALL have ports: ws  output  1  write-strobe phase; 0 = settle/read phase, 1 = write phase.
REQ-011 SHALL have ports: halted  output  1  high while parked at FETCH phase 0 waiting for run or step.
REQ-012 SHALL have ports: bitcnt  output  3  current ALU shift step, 0..7; 0 outside ALU.

Function
REQ-013 SHALL encode major states as {s1,s0}: FETCH=00, DEREF=01, LOAD=10, EXEC=11; ALU is any state with s2|s3=1, and {s1,s0}=00 SHALL hold in ALU.
REQ-014 SHALL keep ns0 = ~s0 and ns1 = ~s1 in every cycle, including reset.
REQ-015 SHALL split every state step into two clocks: ws=0, then ws=1; the state SHALL change only on the clock that ends a ws=1 cycle.
REQ-016 SHALL leave FETCH for DEREF if deref=1, else for LOAD if o2=0, else for EXEC.
REQ-017 SHALL leave DEREF for LOAD if o2=0, else for EXEC.
REQ-018 SHALL leave LOAD for EXEC.
REQ-019 SHALL leave EXEC for ALU step 0 if s2in=1, else for FETCH.
REQ-020 SHALL run ALU for exactly 8 steps (bitcnt 0..7, two clocks each); s2=1 for steps 0..6, s3=1 and s2=0 on step 7, then return to FETCH; s2 and s3 SHALL never both be 1.
REQ-021 SHALL sample deref, o2 and s2in only on the ws=1 cycle of the state being left.
REQ-022 SHALL hold at FETCH with ws=0 and halted=1 when entering FETCH with run=0 and no pending step.
REQ-023 SHALL synchronise step through two flops and detect its rising edge; one edge SHALL set a pending flag.
REQ-024 SHALL clear the pending flag when FETCH phase 0 is released, so exactly one instruction executes per edge.
REQ-025 SHALL ignore further step edges while pending is already set.
REQ-026 SHALL never truncate an instruction when run drops mid-instruction; it completes and then parks at the next FETCH.
REQ-027 SHALL take priority order reset > halt check > normal sequencing when events coincide.
REQ-028 SHALL resume from park on the clock after run=1, entering FETCH ws=0 with halted=0, then ws=1 next clock.

Reset
REQ-029 SHALL on nrst=0 at a clock edge force FETCH, s0=s1=s2=s3=0, ns0=ns1=1, ws=0, bitcnt=0, halted=1, pending=0, and clear the step synchroniser.
REQ-030 SHALL abandon any instruction or ALU sequence in progress when reset is applied mid-operation, with no partial write phase afterwards.

Structure
REQ-031 SHALL take the state encodings (FETCH, DEREF, LOAD, EXEC, ALU) and the ALU step count constant (8) from shared package q2_pkg.
REQ-032 SHALL place the step synchroniser and edge detector in sub-module q2_step_sync; everything else SHALL be one registered next-state process.

Verification
REQ-033 SHALL verify reset: after reset, with run=1, deref=0, o2=1, s2in=0 -> {s1,s0} sequence 00,00,11,11,00 with ws sequence 0,1,0,1,0.
REQ-034 SHALL verify the indirect load: deref=1, o2=0 -> FETCH, DEREF, LOAD, EXEC, each two clocks; 8 clocks back to FETCH.
REQ-035 SHALL verify ALU entry: s2in=1 at the end of EXEC -> 16 ALU clocks; s2=1 for bitcnt 0..6, s3=1 at bitcnt 7, then FETCH with bitcnt=0.
REQ-036 SHALL verify run drop: run 1->0 during LOAD -> EXEC completes, FETCH ws=0 parks with halted=1 and stays 20 clocks.
REQ-037 SHALL verify single step: when halted, one step pulse -> exactly one instruction, then park again; a second edge during that instruction is ignored.
REQ-038 SHALL verify mid-operation reset: nrst=0 at ALU bitcnt=4 -> next cycle FETCH, ws=0, s2=s3=0, halted=1.
